// File: rtl/spike_packet_scheduler_if.sv
// Packet stream between the spike scheduler and its consumer.
// A packet is {origin address, destination address}, accepted on valid && ready.
interface spike_packet_scheduler_if #(
  parameter int ADDR_W = 12
) ();
  logic [2*ADDR_W-1:0] packet;
  logic                packet_valid;
  logic                packet_ready;

  modport master (
    output packet,
    output packet_valid,
    input  packet_ready
  );

  modport slave (
    input  packet,
    input  packet_valid,
    output packet_ready
  );
endinterface

// File: rtl/spike_packet_scheduler.sv
// Turns per-neuron spikes into a stream of {origin, destination} packets by
// walking each spiking neuron's slice of the downstream connection table.
module spike_packet_scheduler #(
  parameter int NUM_NEURONS = 10,
  parameter int ADDR_W      = 12,
  parameter int MAX_CONN    = 30
) (
  input  logic                            CLK,
  input  logic                            clear,
  input  logic [NUM_NEURONS-1:0]          spike,
  input  logic [NUM_NEURONS*ADDR_W-1:0]   neuron_addresses_initialization,
  input  logic [(NUM_NEURONS+1)*5-1:0]    connection_pointer_initialization,
  input  logic [MAX_CONN*ADDR_W-1:0]      downstream_connections_initialization,
  spike_packet_scheduler_if.master        pkt_bus,
  output logic                            busy,
  output logic                            cfg_error,
  output logic [15:0]                     packet_count
);

  localparam int PTR_W = 5;
  localparam int GW    = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_NEURONS-1:0] pending_q, pending_d;
  logic [GW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [PTR_W-1:0]      idx_q, idx_d;
  logic [PTR_W-1:0]      end_q, end_d;
  logic [2*ADDR_W-1:0]   packet_q, packet_d;
  logic                  valid_q, valid_d;
  logic                  cfg_error_d;
  logic [15:0]           count_d;

  logic                  found;
  logic [GW-1:0]         pick;
  logic [PTR_W-1:0]      start_ptr, end_ptr;
  logic                  handshake;

  // Table lookups are explicit muxes so out-of-range indices read zero.
  function automatic logic [ADDR_W-1:0] dst_at(input logic [PTR_W-1:0] i);
    logic [ADDR_W-1:0] r;
    r = '0;
    for (int unsigned j = 0; j < MAX_CONN; j++) begin
      if (PTR_W'(j) == i) r = downstream_connections_initialization[j*ADDR_W +: ADDR_W];
    end
    return r;
  endfunction

  function automatic logic [ADDR_W-1:0] addr_at(input logic [GW-1:0] g);
    logic [ADDR_W-1:0] r;
    r = '0;
    for (int unsigned j = 0; j < NUM_NEURONS; j++) begin
      if (GW'(j) == g) r = neuron_addresses_initialization[j*ADDR_W +: ADDR_W];
    end
    return r;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_at(input int unsigned k);
    logic [PTR_W-1:0] r;
    r = '0;
    for (int unsigned j = 0; j <= NUM_NEURONS; j++) begin
      if (j == k) r = connection_pointer_initialization[j*PTR_W +: PTR_W];
    end
    return r;
  endfunction

  assign start_ptr = ptr_at(32'(grant_q));
  assign end_ptr   = ptr_at(32'(grant_q) + 1);
  assign handshake = valid_q && pkt_bus.packet_ready;

  // First pending neuron at or after rr_ptr, wrapping at NUM_NEURONS-1.
  always_comb begin
    int unsigned n;
    found = 1'b0;
    pick  = '0;
    n     = 0;
    for (int unsigned k = 0; k < NUM_NEURONS; k++) begin
      n = 32'(rr_ptr_q) + k;
      if (n >= NUM_NEURONS) n = n - NUM_NEURONS;
      if (!found && pending_q[GW'(n)]) begin
        found = 1'b1;
        pick  = GW'(n);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    idx_d       = idx_q;
    end_d       = end_q;
    packet_d    = packet_q;
    valid_d     = valid_q;
    cfg_error_d = cfg_error;
    count_d     = packet_count;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          pending_d[pick] = 1'b0;
          grant_d         = pick;
          rr_ptr_d        = (pick == GW'(NUM_NEURONS - 1)) ? '0 : pick + 1'b1;
          state_d         = LOAD;
        end
      end
      LOAD: begin
        idx_d = start_ptr;
        end_d = end_ptr;
        if (end_ptr == start_ptr) begin
          state_d = IDLE;
        end else if ((end_ptr < start_ptr) || (32'(end_ptr) > 32'(MAX_CONN))) begin
          cfg_error_d = 1'b1;
          state_d     = IDLE;
        end else begin
          packet_d = {addr_at(grant_q), dst_at(start_ptr)};
          valid_d  = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (handshake) begin
          idx_d = idx_q + 1'b1;
          if (packet_count != 16'hFFFF) count_d = packet_count + 16'd1;
          if (idx_q == end_q - 1'b1) begin
            valid_d = 1'b0;
            state_d = IDLE;
          end else begin
            // Origin half is already latched; only the destination advances.
            packet_d = {packet_q[2*ADDR_W-1:ADDR_W], dst_at(idx_q + 1'b1)};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Applied last so a new spike survives a same-cycle grant.
    pending_d = pending_d | spike;
  end

  always_ff @(posedge CLK) begin
    if (!clear) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      idx_q        <= '0;
      end_q        <= '0;
      packet_q     <= '0;
      valid_q      <= 1'b0;
      cfg_error    <= 1'b0;
      packet_count <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      idx_q        <= idx_d;
      end_q        <= end_d;
      packet_q     <= packet_d;
      valid_q      <= valid_d;
      cfg_error    <= cfg_error_d;
      packet_count <= count_d;
    end
  end

  assign pkt_bus.packet       = packet_q;
  assign pkt_bus.packet_valid = valid_q;
  assign busy                 = (state_q != IDLE) || (|pending_q);

endmodule

// File: tb/tb_spike_packet_scheduler.sv
// Directed bench for spike_packet_scheduler: latency, backpressure,
// round-robin order, empty/bad pointer ranges, merge and reset behaviour.
module tb_spike_packet_scheduler;

  localparam int NUM_NEURONS = 10;
  localparam int ADDR_W      = 12;
  localparam int MAX_CONN    = 30;

  logic                          CLK = 1'b0;
  logic                          clear;
  logic [NUM_NEURONS-1:0]        spike;
  logic [NUM_NEURONS*ADDR_W-1:0] neuron_addr;
  logic [(NUM_NEURONS+1)*5-1:0]  conn_ptr;
  logic [MAX_CONN*ADDR_W-1:0]    downstream;
  logic                          busy;
  logic                          cfg_error;
  logic [15:0]                   packet_count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  spike_packet_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

  spike_packet_scheduler #(
    .NUM_NEURONS (NUM_NEURONS),
    .ADDR_W      (ADDR_W),
    .MAX_CONN    (MAX_CONN)
  ) dut (
    .CLK                                   (CLK),
    .clear                                 (clear),
    .spike                                 (spike),
    .neuron_addresses_initialization       (neuron_addr),
    .connection_pointer_initialization     (conn_ptr),
    .downstream_connections_initialization (downstream),
    .pkt_bus                               (bus),
    .busy                                  (busy),
    .cfg_error                             (cfg_error),
    .packet_count                          (packet_count)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a valid packet, checks it, then lets the handshake edge pass.
  task automatic next_pkt(input string tag, input logic [23:0] exp);
    int unsigned n;
    n = 0;
    while (!bus.packet_valid && n < 8) begin
      step();
      n++;
    end
    check({tag, "_valid"}, 32'(bus.packet_valid), 32'd1);
    check(tag, 32'(bus.packet), 32'(exp));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Table: n0 -> 0..2, n1 -> 3, n2 -> 4..5, n3 -> 6, n4..n8 empty, n9 -> 7..8
    logic [4:0] ptrs [NUM_NEURONS+1];
    ptrs = '{5'd0, 5'd3, 5'd4, 5'd6, 5'd7, 5'd7, 5'd7, 5'd7, 5'd7, 5'd7, 5'd9};
    for (int unsigned i = 0; i < NUM_NEURONS; i++) neuron_addr[i*ADDR_W +: ADDR_W] = 12'(i + 1);
    for (int unsigned i = 0; i <= NUM_NEURONS; i++) conn_ptr[i*5 +: 5] = ptrs[i];
    for (int unsigned j = 0; j < MAX_CONN; j++) downstream[j*ADDR_W +: ADDR_W] = 12'(j + 10);

    clear = 1'b0;
    spike = '0;
    bus.packet_ready = 1'b1;
    step();
    step();
    check("rst_valid",  32'(bus.packet_valid), 32'd0);
    check("rst_packet", 32'(bus.packet),       32'd0);
    check("rst_busy",   32'(busy),             32'd0);
    check("rst_cfg",    32'(cfg_error),        32'd0);
    check("rst_count",  32'(packet_count),     32'd0);
    clear = 1'b1;

    // Single spike on neuron 0, ready held high
    spike[0] = 1'b1;
    step();
    spike = '0;
    check("s1_busy", 32'(busy), 32'd1);
    step();
    check("s1_lat_valid", 32'(bus.packet_valid), 32'd0);
    step();
    check("s1_p0_valid", 32'(bus.packet_valid), 32'd1);
    check("s1_p0", 32'(bus.packet), 32'h00100A);
    step();
    check("s1_p1", 32'(bus.packet), 32'h00100B);
    step();
    check("s1_p2", 32'(bus.packet), 32'h00100C);
    step();
    check("s1_end_valid", 32'(bus.packet_valid), 32'd0);
    check("s1_count",     32'(packet_count),     32'd3);
    check("s1_end_busy",  32'(busy),             32'd0);

    // Backpressure
    spike[0] = 1'b1;
    step();
    spike = '0;
    step();
    bus.packet_ready = 1'b0;
    step();
    check("bp_valid", 32'(bus.packet_valid), 32'd1);
    check("bp_p0", 32'(bus.packet), 32'h00100A);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_pkt",   32'(bus.packet),       32'h00100A);
      check("bp_hold_valid", 32'(bus.packet_valid), 32'd1);
      check("bp_hold_count", 32'(packet_count),     32'd3);
    end
    bus.packet_ready = 1'b1;
    step();
    check("bp_p1", 32'(bus.packet), 32'h00100B);
    check("bp_count4", 32'(packet_count), 32'd4);
    step();
    check("bp_p2", 32'(bus.packet), 32'h00100C);
    step();
    check("bp_end_valid", 32'(bus.packet_valid), 32'd0);
    check("bp_count6", 32'(packet_count), 32'd6);

    // Round-robin from rr_ptr=0: 2 then 9; a second pair during neuron 2 sends 9 ahead of 2
    clear = 1'b0;
    step();
    clear = 1'b1;
    spike[2] = 1'b1;
    spike[9] = 1'b1;
    step();
    spike = '0;
    next_pkt("rr_n2_p0", 24'h00300E);
    spike[2] = 1'b1;
    spike[9] = 1'b1;
    next_pkt("rr_n2_p1", 24'h00300F);
    spike = '0;
    next_pkt("rr_n9_p0", 24'h00A011);
    next_pkt("rr_n9_p1", 24'h00A012);
    next_pkt("rr_n2b_p0", 24'h00300E);
    next_pkt("rr_n2b_p1", 24'h00300F);
    check("rr_idle_busy", 32'(busy), 32'd0);
    check("rr_count", 32'(packet_count), 32'd6);

    // Empty range on neuron 4
    spike[4] = 1'b1;
    step();
    spike = '0;
    check("zr_busy_a", 32'(busy), 32'd1);
    step();
    check("zr_busy_b", 32'(busy), 32'd1);
    check("zr_valid_b", 32'(bus.packet_valid), 32'd0);
    step();
    check("zr_busy_clr", 32'(busy), 32'd0);
    check("zr_valid", 32'(bus.packet_valid), 32'd0);
    check("zr_cfg", 32'(cfg_error), 32'd0);
    check("zr_count", 32'(packet_count), 32'd6);

    // Reversed range on neuron 4: ptr[4]=7, ptr[5]=3
    conn_ptr[5*5 +: 5] = 5'd3;
    spike[4] = 1'b1;
    step();
    spike = '0;
    step();
    check("inv_valid_a", 32'(bus.packet_valid), 32'd0);
    step();
    check("inv_cfg", 32'(cfg_error), 32'd1);
    check("inv_busy", 32'(busy), 32'd0);
    check("inv_valid", 32'(bus.packet_valid), 32'd0);
    check("inv_count", 32'(packet_count), 32'd6);
    conn_ptr[5*5 +: 5] = 5'd7;
    step();
    step();
    step();
    check("inv_sticky", 32'(cfg_error), 32'd1);

    // Merge: repeat spike on neuron 1 while it is still pending
    clear = 1'b0;
    step();
    check("rst2_cfg", 32'(cfg_error), 32'd0);
    clear = 1'b1;
    spike[0] = 1'b1;
    spike[1] = 1'b1;
    step();
    spike = '0;
    next_pkt("m_n0_p0", 24'h00100A);
    spike[1] = 1'b1;
    next_pkt("m_n0_p1", 24'h00100B);
    spike = '0;
    next_pkt("m_n0_p2", 24'h00100C);
    next_pkt("m_n1", 24'h00200D);
    for (int i = 0; i < 3; i++) begin
      check("m_once_valid", 32'(bus.packet_valid), 32'd0);
      step();
    end
    check("m_count", 32'(packet_count), 32'd4);
    check("m_busy", 32'(busy), 32'd0);

    // Spike held through its own grant edge re-arms the neuron
    spike[1] = 1'b1;
    step();
    step();
    spike = '0;
    next_pkt("sw_p0", 24'h00200D);
    next_pkt("sw_p1", 24'h00200D);
    step();
    step();
    check("sw_end_valid", 32'(bus.packet_valid), 32'd0);
    check("sw_count", 32'(packet_count), 32'd6);

    // Reset in the middle of SEND; spikes during reset are ignored
    spike[0] = 1'b1;
    step();
    spike = '0;
    step();
    step();
    check("mr_sending", 32'(bus.packet), 32'h00100A);
    step();
    clear = 1'b0;
    spike[3] = 1'b1;
    step();
    check("mr_valid", 32'(bus.packet_valid), 32'd0);
    check("mr_count", 32'(packet_count), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_packet", 32'(bus.packet), 32'd0);
    step();
    spike = '0;
    clear = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("mr_quiet_valid", 32'(bus.packet_valid), 32'd0);
    end
    check("mr_quiet_busy", 32'(busy), 32'd0);
    check("mr_quiet_count", 32'(packet_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
